// File: rtl/timetag_pkg.sv
// timetag_pkg: constants and types shared by the host command receive path.
// Holds the command opcodes, frame lengths, the strobe-FSM state encoding and
// a saturating increment helper for the framing-error counter.
package timetag_pkg;

  localparam logic [7:0] OP_REG_WR = 8'h01;
  localparam logic [7:0] OP_REG_RD = 8'h02;

  localparam int WR_FRAME_LEN = 7;
  localparam int RD_FRAME_LEN = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_RECOVER
  } rxState_t;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ft_rx_phy.sv
// ft_rx_phy: FT2232 receive-side physical layer.
// Synchronizes RXF#, arbitrates for the shared data bus and generates the RD#
// strobe, handing each captured byte to the parser as a one-cycle pulse.
module ft_rx_phy
  import timetag_pkg::*;
#(
  parameter int RD_WAIT = 4,
  parameter int RD_HOLD = 2
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       nrxf_i,
  input  logic [7:0] d_i,
  input  logic       bus_gnt_i,
  output logic       nrd_o,
  output logic       bus_req_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o
);

  localparam logic [7:0] WAIT_LAST = 8'(RD_WAIT - 1);
  localparam logic [7:0] HOLD_LAST = 8'(RD_HOLD);

  rxState_t   r_state;
  logic [7:0] r_cnt;
  logic       r_syncMeta;
  logic       r_rxfSync;

  // Two-flop synchronizer for the asynchronous RXF# input; idles high (no data).
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_syncMeta <= 1'b1;
      r_rxfSync  <= 1'b1;
    end else begin
      r_syncMeta <= nrxf_i;
      r_rxfSync  <= r_syncMeta;
    end
  end

  // Strobe FSM: RD# low for RD_WAIT cycles with capture on the last one, then a
  // recovery gap. RECOVER lasts RD_HOLD+1 cycles and the IDLE decision cycle
  // adds one more, so RD# is high RD_HOLD+2 cycles, flushing a stale RXF#.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      nrd_o        <= 1'b1;
      byte_o       <= 8'd0;
      byte_valid_o <= 1'b0;
    end else begin
      byte_valid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_rxfSync && bus_gnt_i) begin
            r_state <= ST_STROBE;
            r_cnt   <= 8'd0;
            nrd_o   <= 1'b0;
          end
        end
        ST_STROBE: begin
          if (r_cnt == WAIT_LAST) begin
            byte_o       <= d_i;
            byte_valid_o <= 1'b1;
            nrd_o        <= 1'b1;
            r_cnt        <= 8'd0;
            r_state      <= ST_RECOVER;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_RECOVER: begin
          if (r_cnt == HOLD_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 8'd0;
          nrd_o   <= 1'b1;
        end
      endcase
    end
  end

  assign bus_req_o = (r_state != ST_IDLE) || !r_rxfSync;

endmodule

// File: rtl/host_cmd_rx.sv
// host_cmd_rx: host link receive engine. Frames bytes from ft_rx_phy into
// register write/read commands and drives the register bus strobes.
// Optional feature: define HOST_CMD_RX_TIMEOUT_EN to discard partial frames
// after TIMEOUT idle cycles (counted as a framing error).
module host_cmd_rx
  import timetag_pkg::*;
#(
  parameter int RD_WAIT = 4,
  parameter int RD_HOLD = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        nrxf_i,
  input  logic [7:0]  d_i,
  output logic        nrd_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic [15:0] reg_addr_o,
  output logic [31:0] reg_data_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  output logic [7:0]  err_cnt_o
);

  logic [7:0]  w_byte;
  logic        w_byteValid;
  logic        w_timeout;
  logic [2:0]  r_idx;
  logic [7:0]  r_op;
  logic [15:0] r_addrBuf;
  logic [23:0] r_dataBuf;

  ft_rx_phy #(
    .RD_WAIT(RD_WAIT),
    .RD_HOLD(RD_HOLD)
  ) u_phy (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .nrxf_i      (nrxf_i),
    .d_i         (d_i),
    .bus_gnt_i   (bus_gnt_i),
    .nrd_o       (nrd_o),
    .bus_req_o   (bus_req_o),
    .byte_o      (w_byte),
    .byte_valid_o(w_byteValid)
  );

`ifdef HOST_CMD_RX_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] r_toCnt;

  assign w_timeout = (r_idx != 3'd0) && !w_byteValid && (r_toCnt == TO_LAST);

  // Idle timer for a partial frame; a captured byte always restarts it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_toCnt <= 16'd0;
    end else if (w_byteValid || r_idx == 3'd0 || w_timeout) begin
      r_toCnt <= 16'd0;
    end else begin
      r_toCnt <= r_toCnt + 16'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Frame parser: opcode byte, little-endian address, then data for writes.
  // Unknown opcodes are dropped at index 0 so the stream resynchronizes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_idx      <= 3'd0;
      r_op       <= 8'd0;
      r_addrBuf  <= 16'd0;
      r_dataBuf  <= 24'd0;
      reg_addr_o <= 16'd0;
      reg_data_o <= 32'd0;
      reg_wr_o   <= 1'b0;
      reg_rd_o   <= 1'b0;
      err_cnt_o  <= 8'd0;
    end else begin
      reg_wr_o <= 1'b0;
      reg_rd_o <= 1'b0;
      if (w_byteValid) begin
        if (r_idx == 3'd0) begin
          if (w_byte == OP_REG_WR || w_byte == OP_REG_RD) begin
            r_op  <= w_byte;
            r_idx <= 3'd1;
          end else begin
            err_cnt_o <= satInc8(err_cnt_o);
          end
        end else begin
          case (r_idx)
            3'd1: r_addrBuf[7:0]   <= w_byte;
            3'd2: r_addrBuf[15:8]  <= w_byte;
            3'd3: r_dataBuf[7:0]   <= w_byte;
            3'd4: r_dataBuf[15:8]  <= w_byte;
            3'd5: r_dataBuf[23:16] <= w_byte;
            default: ;
          endcase
          if (r_op == OP_REG_RD && r_idx == 3'(RD_FRAME_LEN - 1)) begin
            reg_addr_o <= {w_byte, r_addrBuf[7:0]};
            reg_rd_o   <= 1'b1;
            r_idx      <= 3'd0;
          end else if (r_op == OP_REG_WR && r_idx == 3'(WR_FRAME_LEN - 1)) begin
            reg_addr_o <= r_addrBuf;
            reg_data_o <= {w_byte, r_dataBuf};
            reg_wr_o   <= 1'b1;
            r_idx      <= 3'd0;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
      end else if (w_timeout) begin
        r_idx     <= 3'd0;
        err_cnt_o <= satInc8(err_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_rx.sv
// tb_host_cmd_rx: self-checking bench for host_cmd_rx.
// An FT2232 model serves bytes from a queue; expected register-bus strobes are
// pushed to a scoreboard and popped by an independent monitor.
module tb_host_cmd_rx;

  typedef struct {
    bit          isWrite;
    logic [15:0] addr;
    logic [31:0] data;
  } expTxn_t;

  logic        clk;
  logic        resetN;
  logic        nrxf;
  logic [7:0]  dIn;
  logic        nrd;
  logic        busReq;
  logic        busGnt;
  logic [15:0] regAddr;
  logic [31:0] regData;
  logic        regWr;
  logic        regRd;
  logic [7:0]  errCnt;

  expTxn_t    sbQ[$];
  logic [7:0] ftQ[$];
  logic [7:0] frame[$];

  int compared   = 0;
  int mismatched = 0;
  int cycleCnt   = 0;
  int holdoff    = 0;
  int lowRun     = 0;
  int lastFall   = 0;
  bit inRead     = 0;
  bit backToBack = 0;
  bit ignoreRun  = 0;
  bit prevNrd    = 1;
  logic [31:0] expData = 32'd0;

  host_cmd_rx #(
    .RD_WAIT(4),
    .RD_HOLD(2),
    .TIMEOUT(100)
  ) dut (
    .clk_i     (clk),
    .reset_ni  (resetN),
    .nrxf_i    (nrxf),
    .d_i       (dIn),
    .nrd_o     (nrd),
    .bus_req_o (busReq),
    .bus_gnt_i (busGnt),
    .reg_addr_o(regAddr),
    .reg_data_o(regData),
    .reg_wr_o  (regWr),
    .reg_rd_o  (regRd),
    .err_cnt_o (errCnt)
  );

  // Free-running clock and cycle counter used for spacing measurements.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] bytes[$]);
    foreach (bytes[i]) ftQ.push_back(bytes[i]);
  endtask

  task automatic expectTxn(input bit isWrite, input logic [15:0] addr,
                           input logic [31:0] data);
    expTxn_t t;
    t.isWrite = isWrite;
    t.addr    = addr;
    t.data    = data;
    sbQ.push_back(t);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((ftQ.size() != 0 || sbQ.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ftQ.size() != 0 || sbQ.size() != 0)
      checkOutput("drainTimeout", ftQ.size() + sbQ.size(), 0);
    repeat (12) @(negedge clk);
  endtask

  // FT2232 model: RXF# low while bytes are queued, high briefly after each read.
  initial begin
    nrxf = 1'b1;
    forever begin
      @(negedge clk);
      if (holdoff > 0) holdoff--;
      nrxf = (holdoff == 0 && ftQ.size() != 0) ? 1'b0 : 1'b1;
    end
  end

  always @(negedge nrd) begin
    inRead = 1;
    if (ftQ.size() != 0) dIn = ftQ[0];
  end

  // Byte is consumed on RD# rising; the bus is then trashed so a late sample shows.
  always @(posedge nrd) begin
    if (inRead) begin
      inRead = 0;
      if (ftQ.size() != 0) void'(ftQ.pop_front());
      dIn        = 8'hEE;
      holdoff    = 2;
      nrxf       = 1'b1;
      backToBack = (ftQ.size() != 0) && busGnt;
    end
  end

  // Monitor: scoreboard compare on each strobe, plus RD# width and spacing.
  always @(negedge clk) begin
    if (resetN && (regWr || regRd)) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedStrobe", {30'd0, regWr, regRd}, 32'd0);
      end else begin
        expTxn_t e;
        e = sbQ.pop_front();
        checkOutput("strobeKind", {30'd0, regWr, regRd}, e.isWrite ? 32'd2 : 32'd1);
        checkOutput("regAddr", {16'd0, regAddr}, {16'd0, e.addr});
        checkOutput("regData", regData, e.data);
      end
    end
    if (!nrd) begin
      lowRun++;
    end else begin
      if (lowRun > 0 && !ignoreRun) checkOutput("nrdLowCycles", lowRun, 4);
      lowRun = 0;
    end
    if (!nrd && prevNrd) begin
      if (backToBack && !ignoreRun) checkOutput("byteSpacing", cycleCnt - lastFall, 8);
      lastFall   = cycleCnt;
      backToBack = 0;
    end
    prevNrd = nrd;
  end

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int n;
    resetN = 1'b0;
    busGnt = 1'b0;
    dIn    = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rstNrd", nrd, 1);
    checkOutput("rstBusReq", busReq, 0);
    checkOutput("rstRegWr", regWr, 0);
    checkOutput("rstRegRd", regRd, 0);
    checkOutput("rstRegAddr", regAddr, 0);
    checkOutput("rstRegData", regData, 0);
    checkOutput("rstErrCnt", errCnt, 0);
    resetN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] write frame with grant withheld");
    frame = '{8'h01, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    expData = 32'h0000_0001;
    expectTxn(1'b1, 16'h0010, expData);
    applyStimulus(frame);
    repeat (20) @(negedge clk);
    checkOutput("noGntNrd", nrd, 1);
    checkOutput("noGntBusReq", busReq, 1);
    busGnt = 1'b1;
    waitDrain(300);
    checkOutput("errAfterWrite", errCnt, 0);

    $display("[TB] read frame");
    frame = '{8'h02, 8'h01, 8'h00};
    expectTxn(1'b0, 16'h0001, expData);
    applyStimulus(frame);
    waitDrain(300);

    $display("[TB] bad opcode then write");
    frame = '{8'hFF, 8'h01, 8'h20, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    expData = 32'h1234_5678;
    expectTxn(1'b1, 16'h0020, expData);
    applyStimulus(frame);
    waitDrain(300);
    checkOutput("errAfterBadOp", errCnt, 1);

    $display("[TB] partial frame then idle");
    frame = '{8'h01, 8'h10};
    applyStimulus(frame);
    waitDrain(300);
    repeat (150) @(negedge clk);
`ifdef HOST_CMD_RX_TIMEOUT_EN
    checkOutput("errAfterTimeout", errCnt, 2);
    frame = '{8'h02, 8'h01, 8'h00};
    expectTxn(1'b0, 16'h0001, expData);
    applyStimulus(frame);
    waitDrain(300);
`else
    checkOutput("errNoTimeout", errCnt, 1);
    frame = '{8'h02, 8'h01, 8'h00};
    applyStimulus(frame);
    waitDrain(300);
`endif

    $display("[TB] reset during read strobe");
    frame = '{8'h02};
    applyStimulus(frame);
    n = 0;
    while (nrd && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("nrdLowBeforeReset", nrd, 0);
    ignoreRun = 1;
    @(negedge clk);
    resetN = 1'b0;
    #1;
    checkOutput("midRstNrd", nrd, 1);
    checkOutput("midRstBusReq", busReq, 0);
    checkOutput("midRstRegWr", regWr, 0);
    checkOutput("midRstRegRd", regRd, 0);
    checkOutput("midRstRegAddr", regAddr, 0);
    checkOutput("midRstRegData", regData, 0);
    checkOutput("midRstErrCnt", errCnt, 0);
    ftQ.delete();
    backToBack = 0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
    ignoreRun = 0;
    expData = 32'd0;
    frame = '{8'h02, 8'h05, 8'h00};
    expectTxn(1'b0, 16'h0005, expData);
    applyStimulus(frame);
    waitDrain(300);
    checkOutput("errAfterReset", errCnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
